// File: rtl/return_addr_stack_pkg.sv
// Shared constants and types for the return-address stack: register aliases,
// operation decode and the rollback restore-count helper.
package return_addr_stack_pkg;

    localparam logic [4:0] RA_REG   = 5'd1;
    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam logic       ZERO     = 1'b0;

    typedef enum logic [2:0] {
        OP_IDLE     = 3'd0,
        OP_PUSH     = 3'd1,
        OP_POP      = 3'd2,
        OP_PUSH_POP = 3'd3,
        OP_ROLLBACK = 3'd4
    } ras_op_e;

    // Number of entries restored by the two pop-undo rollback sources.
    function automatic logic [1:0] rb_restore_count(input logic push_id, input logic push_ex);
        return {1'b0, push_id} + {1'b0, push_ex};
    endfunction

    // Rollbacks win over push/pop; otherwise push/pop select the operation.
    function automatic ras_op_e decode_op(input logic push, input logic pop, input logic any_rb);
        ras_op_e op;
        if (any_rb) begin
            op = OP_ROLLBACK;
        end else begin
            case ({push, pop})
                2'b10:   op = OP_PUSH;
                2'b01:   op = OP_POP;
                2'b11:   op = OP_PUSH_POP;
                default: op = OP_IDLE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/return_addr_stack_mem.sv
// Circular return-address storage: one synchronous write port and one
// asynchronous read port; contents are intentionally not reset.
module ras_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack: circular storage with pointer/count management,
// pipeline-flush rollback and ra-alias tracking.
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [AW-1:0]              push_addr,
    input  logic                       pop,
    input  logic                       rollback_pop_id,
    input  logic                       rollback_push_id,
    input  logic                       rollback_push_ex,
    input  logic                       wr_ra_track_en,
    input  logic [4:0]                 wr_ra_track_data,
    output logic [AW-1:0]              ras_top,
    output logic                       ras_valid,
    output logic [$clog2(DEPTH):0]     ras_count,
    output logic [4:0]                 ra_track
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] TP_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_EMPTY = {CW{1'b0}};

    logic [PW-1:0] tp_r;
    logic [PW-1:0] tp_next_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          valid_r;
    logic [4:0]    ra_track_r;
    logic [4:0]    ra_track_next_s;

    logic          any_rb_s;
    logic [1:0]    rb_up_s;
    ras_op_e       op_s;
    logic [CW:0]   rb_sum_s;
    logic [CW:0]   rb_diff_s;
    logic [CW-1:0] rb_count_s;
    logic          push_accepted_s;

    logic          mem_we_s;
    logic [PW-1:0] mem_waddr_s;
    logic [AW-1:0] mem_wdata_s;
    logic [PW-1:0] top_idx_s;
    logic [AW-1:0] top_data_s;

    assign any_rb_s  = rollback_pop_id | rollback_push_id | rollback_push_ex;
    assign rb_up_s   = rb_restore_count(rollback_push_id, rollback_push_ex);
    assign op_s      = decode_op(push, pop, any_rb_s);
    assign top_idx_s = tp_r - TP_ONE;

    // Rollback count: count + restored - undone, clamped to [0, DEPTH].
    always_comb begin
        rb_sum_s  = CW'(count_r) + (CW+1)'(rb_up_s);
        rb_diff_s = {(CW+1){1'b0}};
        rb_count_s = CNT_EMPTY;
        if (rb_sum_s < (CW+1)'(rollback_pop_id)) begin
            rb_count_s = CNT_EMPTY;
        end else begin
            rb_diff_s = rb_sum_s - (CW+1)'(rollback_pop_id);
            if (rb_diff_s > (CW+1)'(DEPTH)) begin
                rb_count_s = CNT_FULL;
            end else begin
                rb_count_s = rb_diff_s[CW-1:0];
            end
        end
    end

    // Pointer, count and storage-write decode for the selected operation.
    always_comb begin
        tp_next_s       = tp_r;
        count_next_s    = count_r;
        mem_we_s        = ZERO;
        mem_waddr_s     = tp_r;
        mem_wdata_s     = push_addr;
        push_accepted_s = 1'b0;
        case (op_s)
            OP_ROLLBACK: begin
                // mem is never written here so restored entries keep their old value
                tp_next_s    = tp_r + PW'(rb_up_s) - PW'(rollback_pop_id);
                count_next_s = rb_count_s;
            end
            OP_PUSH: begin
                mem_we_s        = 1'b1;
                mem_waddr_s     = tp_r;
                tp_next_s       = tp_r + TP_ONE;
                push_accepted_s = 1'b1;
                if (count_r == CNT_FULL) begin
                    count_next_s = CNT_FULL;
                end else begin
                    count_next_s = count_r + CNT_ONE;
                end
            end
            OP_POP: begin
                if (count_r != CNT_EMPTY) begin
                    tp_next_s    = tp_r - TP_ONE;
                    count_next_s = count_r - CNT_ONE;
                end else begin
                    tp_next_s    = tp_r;
                    count_next_s = count_r;
                end
            end
            OP_PUSH_POP: begin
                // Replace the top in place; an empty stack gains its first entry.
                mem_we_s        = 1'b1;
                mem_waddr_s     = top_idx_s;
                push_accepted_s = 1'b1;
                if (count_r == CNT_EMPTY) begin
                    count_next_s = CNT_ONE;
                end else begin
                    count_next_s = count_r;
                end
            end
            default: begin
                tp_next_s    = tp_r;
                count_next_s = count_r;
            end
        endcase
    end

    // ra-alias tracking: explicit writes win over the implicit push update.
    always_comb begin
        if (wr_ra_track_en) begin
            ra_track_next_s = wr_ra_track_data;
        end else if (push_accepted_s) begin
            ra_track_next_s = RA_REG;
        end else begin
            ra_track_next_s = ra_track_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tp_r       <= {PW{1'b0}};
            count_r    <= CNT_EMPTY;
            valid_r    <= 1'b0;
            ra_track_r <= RA_REG;
        end else begin
            tp_r       <= tp_next_s;
            count_r    <= count_next_s;
            valid_r    <= (count_next_s != CNT_EMPTY);
            ra_track_r <= ra_track_next_s;
        end
    end

    ras_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PW    (PW)
    ) u_ras_mem (
        .clk   (clk),
        .we    (mem_we_s & rst_n),
        .waddr (mem_waddr_s),
        .wdata (mem_wdata_s),
        .raddr (top_idx_s),
        .rdata (top_data_s)
    );

    assign ras_top   = top_data_s;
    assign ras_valid = valid_r;
    assign ras_count = count_r;
    assign ra_track  = ra_track_r;

endmodule

// File: tb/tb_return_addr_stack.sv
// Scoreboard bench for return_addr_stack: directed scenarios plus random
// traffic checked against a behavioural array model.
module tb_return_addr_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push;
    logic [AW-1:0] push_addr;
    logic          pop;
    logic          rollback_pop_id;
    logic          rollback_push_id;
    logic          rollback_push_ex;
    logic          wr_ra_track_en;
    logic [4:0]    wr_ra_track_data;
    logic [AW-1:0] ras_top;
    logic          ras_valid;
    logic [CW-1:0] ras_count;
    logic [4:0]    ra_track;

    always #5 clk = ~clk;

    return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .push             (push),
        .push_addr        (push_addr),
        .pop              (pop),
        .rollback_pop_id  (rollback_pop_id),
        .rollback_push_id (rollback_push_id),
        .rollback_push_ex (rollback_push_ex),
        .wr_ra_track_en   (wr_ra_track_en),
        .wr_ra_track_data (wr_ra_track_data),
        .ras_top          (ras_top),
        .ras_valid        (ras_valid),
        .ras_count        (ras_count),
        .ra_track         (ra_track)
    );

    typedef struct {
        logic [AW-1:0] top;
        bit            top_known;
        int            cnt;
        int            track;
        int            step;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int step_no = 0;

    // Behavioural model: slot array, free-slot index and live count.
    logic [AW-1:0] m_mem [DEPTH];
    bit            m_wr  [DEPTH];
    int            m_tp = 0;
    int            m_cnt = 0;
    int            m_track = 1;

    function automatic int wrap(input int v);
        return ((v % DEPTH) + DEPTH) % DEPTH;
    endfunction

    task automatic model_step(input logic r, input logic pu, input logic [AW-1:0] pa,
                              input logic po, input logic rpid, input logic rpex,
                              input logic rpop, input logic wen, input logic [4:0] wd);
        bit pushed = 0;
        int d;
        if (!r) begin
            m_tp = 0; m_cnt = 0; m_track = 1;
        end else begin
            if (rpid || rpex || rpop) begin
                d = int'(rpid) + int'(rpex) - int'(rpop);
                m_tp  = wrap(m_tp + d);
                m_cnt = m_cnt + d;
                if (m_cnt < 0) m_cnt = 0;
                if (m_cnt > DEPTH) m_cnt = DEPTH;
            end else if (pu && po) begin
                m_mem[wrap(m_tp - 1)] = pa; m_wr[wrap(m_tp - 1)] = 1;
                if (m_cnt == 0) m_cnt = 1;
                pushed = 1;
            end else if (pu) begin
                m_mem[m_tp] = pa; m_wr[m_tp] = 1;
                m_tp = wrap(m_tp + 1);
                if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
                pushed = 1;
            end else if (po) begin
                if (m_cnt > 0) begin
                    m_tp = wrap(m_tp - 1);
                    m_cnt = m_cnt - 1;
                end
            end
            if (wen) m_track = int'(wd);
            else if (pushed) m_track = 1;
        end
    endtask

    task automatic drive(input logic r, input logic pu, input logic [AW-1:0] pa,
                         input logic po, input logic rpid, input logic rpex,
                         input logic rpop, input logic wen, input logic [4:0] wd);
        exp_t e;
        rst_n = r; push = pu; push_addr = pa; pop = po;
        rollback_push_id = rpid; rollback_push_ex = rpex; rollback_pop_id = rpop;
        wr_ra_track_en = wen; wr_ra_track_data = wd;
        @(posedge clk);
        model_step(r, pu, pa, po, rpid, rpex, rpop, wen, wd);
        step_no++;
        e.cnt = m_cnt;
        e.track = m_track;
        e.step = step_no;
        e.top_known = (m_cnt > 0) && m_wr[wrap(m_tp - 1)];
        e.top = m_mem[wrap(m_tp - 1)];
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();   drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); endtask
    task automatic do_push(input logic [AW-1:0] a); drive(1'b1, 1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); endtask
    task automatic do_pop();     drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); endtask
    task automatic do_rb(input logic pid, input logic pex, input logic ppop);
        drive(1'b1, 1'b0, 32'h0, 1'b0, pid, pex, ppop, 1'b0, 5'd0);
    endtask

    // Monitor: the DUT presents state every cycle; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (int'(ras_count) != e.cnt) begin
                    errors++;
                    $display("FAIL count step %0d: got %0d expected %0d", e.step, ras_count, e.cnt);
                end
                checks++;
                if (ras_valid !== (e.cnt != 0)) begin
                    errors++;
                    $display("FAIL valid step %0d: got %0b expected %0b", e.step, ras_valid, e.cnt != 0);
                end
                checks++;
                if (int'(ra_track) != e.track) begin
                    errors++;
                    $display("FAIL ra_track step %0d: got %0d expected %0d", e.step, ra_track, e.track);
                end
                if (e.top_known) begin
                    checks++;
                    if (ras_top !== e.top) begin
                        errors++;
                        $display("FAIL top step %0d: got %h expected %h", e.step, ras_top, e.top);
                    end
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        int sel;
        for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
        rst_n = 1'b0; push = 1'b0; push_addr = '0; pop = 1'b0;
        rollback_pop_id = 1'b0; rollback_push_id = 1'b0; rollback_push_ex = 1'b0;
        wr_ra_track_en = 1'b0; wr_ra_track_data = 5'd0;
        @(negedge clk);
        do_reset(); do_reset();

        // Basic push/pop.
        do_push(32'h100); do_push(32'h200); do_push(32'h300); do_pop();

        // Overflow then drain past empty.
        do_reset();
        for (int i = 1; i <= 9; i++) do_push(32'(i * 16));
        for (int i = 0; i < 9; i++) do_pop();

        // Restore two pops at once.
        do_reset();
        do_push(32'hA0); do_push(32'hB0); do_pop(); do_pop();
        do_rb(1'b1, 1'b1, 1'b0);

        // Push overridden by a rollback of the previous push.
        do_push(32'hC0);
        drive(1'b1, 1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);

        // Replace top with simultaneous push and pop.
        do_push(32'h44);
        drive(1'b1, 1'b1, 32'h88, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

        // ra-alias tracking.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        do_push(32'h1234);
        drive(1'b1, 1'b1, 32'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);

        // Empty-stack edge cases: pop undo and push/pop on empty.
        do_reset();
        do_rb(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 32'hE0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Random traffic, including reset asserted alongside other inputs.
        for (int n = 0; n < 800; n++) begin
            sel = int'($urandom_range(0, 99));
            drive((sel >= 2) ? 1'b1 : 1'b0,
                  $urandom_range(0, 99) < 45, $urandom,
                  $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 10,
                  5'($urandom_range(0, 31)));
        end

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
